pc_fetch_seq: RTL and testbench

PC_FETCH_SEQ -- requirements
Module: pc_fetch_seq

---
 rtl/pc_cu_pkg.sv | 25 ++
 rtl/pc_intr_arb.sv | 44 ++++
 rtl/pc_fetch_seq.sv | 157 +++++++++++++++
 tb/tb_pc_fetch_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_cu_pkg.sv
// Shared definitions for the PC fetch/sequencing control unit:
// FSM states, opcode values, pc_src encodings and addr_src bases.
package pc_cu_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_FETCH  = 2'd1,
    ST_FETCHX = 2'd2,
    ST_DONE   = 2'd3
  } pc_state_t;

  localparam logic [3:0] OP_BRANCH = 4'd9;
  localparam logic [3:0] OP_LOOP   = 4'd10;
  localparam logic [3:0] OP_JMP    = 4'd11;

  localparam logic [1:0] PCSRC_RB_EX = 2'b00;
  localparam logic [1:0] PCSRC_VEC   = 2'b01;
  localparam logic [1:0] PCSRC_RB_D  = 2'b10;
  localparam logic [1:0] PCSRC_DATA  = 2'b11;

  localparam int ADDR_FETCH     = 0;
  localparam int ADDR_RESET     = 1;
  localparam int ADDR_INTR_BASE = 2;

endpackage

// File: rtl/pc_intr_arb.sv
// Interrupt pending register with lowest-index-first selection.
// A request arriving in the same cycle as its own acknowledge stays pending.
module pc_intr_arb
  import pc_cu_pkg::*;
#(
  parameter int NUM_VEC = 4,
  parameter int VEC_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_VEC-1:0] i_req,
  input  logic               i_en,
  input  logic               i_take,
  output logic               o_any,
  output logic [VEC_W-1:0]   o_idx,
  output logic [NUM_VEC-1:0] o_ack
);

  logic [NUM_VEC-1:0] r_pend;
  logic [NUM_VEC-1:0] w_grant;
  logic               w_found;

  always_comb begin
    w_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_VEC; i++) begin
      if (!w_found && r_pend[i]) begin
        w_grant[i] = 1'b1;
        o_idx      = VEC_W'(i);
        w_found    = 1'b1;
      end
    end
  end

  assign o_any = |r_pend;
  assign o_ack = (i_take && i_en) ? w_grant : '0;

  always_ff @(posedge clk) begin
    if (reset) r_pend <= '0;
    else       r_pend <= (r_pend & ~o_ack) | i_req;
  end

endmodule

// File: rtl/pc_fetch_seq.sv
// PC fetch sequencer: walks multi-byte instruction fetch, then picks the
// next-PC source (interrupt vector, branch, loop, jump/call/return) at DONE.
module pc_fetch_seq
  import pc_cu_pkg::*;
#(
  parameter  int MAX_BYTES = 3,
  parameter  int NUM_VEC   = 4,
  localparam int LEN_W     = $clog2(MAX_BYTES + 1),
  localparam int IDX_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1,
  localparam int VEC_W     = $clog2(NUM_VEC + 2)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         opcode,
  input  logic [1:0]         brx,
  input  logic [3:0]         flags,
  input  logic [LEN_W-1:0]   instr_bytes,
  input  logic               mem_ready,
  input  logic               stall,
  input  logic [NUM_VEC-1:0] intr_req,
  input  logic               intr_en,
  output logic               pc_en,
  output logic               pc_load,
  output logic [1:0]         pc_src,
  output logic [VEC_W-1:0]   addr_src,
  output logic               fetch_req,
  output logic [IDX_W-1:0]   byte_idx,
  output logic               instr_done,
  output logic [NUM_VEC-1:0] intr_ack
);

  pc_state_t        r_state, w_next;
  logic [IDX_W-1:0] r_byte_idx;
  logic [LEN_W-1:0] r_len;
  logic             r_pc_loaded;
  logic             w_accept;
  logic             w_last;
  logic [LEN_W-1:0] w_len;
  logic             w_pend_any;
  logic             w_intr_go;
  logic [VEC_W-1:0] w_vec_idx;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] b);
    if (b == '0)                          return LEN_W'(1);
    else if (b > LEN_W'(MAX_BYTES))       return LEN_W'(MAX_BYTES);
    else                                  return b;
  endfunction

  assign w_accept  = mem_ready && !stall;
  assign w_len     = clamp_len(instr_bytes);
  assign w_last    = (LEN_W'(r_byte_idx) == (r_len - LEN_W'(1)));
  assign w_intr_go = intr_en && w_pend_any;

  pc_intr_arb #(
    .NUM_VEC (NUM_VEC),
    .VEC_W   (VEC_W)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .i_req  (intr_req),
    .i_en   (intr_en),
    .i_take (r_state == ST_DONE),
    .o_any  (w_pend_any),
    .o_idx  (w_vec_idx),
    .o_ack  (intr_ack)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RESET;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET:  w_next = ST_FETCH;
      ST_FETCH:  if (w_accept) w_next = (w_len == LEN_W'(1)) ? ST_DONE : ST_FETCHX;
      ST_FETCHX: if (w_accept && w_last) w_next = ST_DONE;
      ST_DONE:   w_next = ST_FETCH;
      default:   w_next = ST_RESET;
    endcase
  end

  always_comb begin
    pc_en      = 1'b0;
    pc_load    = 1'b0;
    pc_src     = PCSRC_RB_EX;
    addr_src   = VEC_W'(ADDR_FETCH);
    fetch_req  = 1'b0;
    byte_idx   = '0;
    instr_done = 1'b0;
    case (r_state)
      ST_RESET: begin
        pc_en    = 1'b1;
        pc_load  = 1'b1;
        pc_src   = PCSRC_VEC;
        addr_src = VEC_W'(ADDR_RESET);
      end
      // After a load the PC already points at the first byte, so skip the increment.
      ST_FETCH: begin
        fetch_req = 1'b1;
        pc_en     = w_accept && !r_pc_loaded;
      end
      ST_FETCHX: begin
        fetch_req = 1'b1;
        byte_idx  = r_byte_idx;
        pc_en     = w_accept;
      end
      ST_DONE: begin
        instr_done = 1'b1;
        if (w_intr_go) begin
          pc_en    = 1'b1;
          pc_load  = 1'b1;
          pc_src   = PCSRC_VEC;
          addr_src = VEC_W'(ADDR_INTR_BASE) + w_vec_idx;
        end else if (opcode == OP_BRANCH && flags[brx]) begin
          pc_en   = 1'b1;
          pc_load = 1'b1;
          pc_src  = PCSRC_RB_EX;
        end else if (opcode == OP_LOOP && !flags[0]) begin
          pc_en   = 1'b1;
          pc_load = 1'b1;
          pc_src  = PCSRC_RB_EX;
        end else if (opcode == OP_JMP) begin
          pc_en   = 1'b1;
          pc_load = 1'b1;
          pc_src  = brx[1] ? PCSRC_DATA : PCSRC_RB_D;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_idx  <= '0;
      r_len       <= LEN_W'(1);
      r_pc_loaded <= 1'b1;
    end else begin
      case (r_state)
        ST_RESET: r_pc_loaded <= 1'b1;
        ST_FETCH: if (w_accept) begin
          r_pc_loaded <= 1'b0;
          r_len       <= w_len;
          r_byte_idx  <= IDX_W'(1);
        end
        ST_FETCHX: if (w_accept) r_byte_idx <= r_byte_idx + IDX_W'(1);
        ST_DONE: begin
          r_pc_loaded <= pc_load;
          r_byte_idx  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Scoreboard bench for pc_fetch_seq: each scenario queues per-cycle stimulus
// with the output vector it must produce, then replays and compares.
module tb_pc_fetch_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = '0;
  logic [1:0] brx = '0;
  logic [3:0] flags = '0;
  logic [1:0] instr_bytes = 2'd1;
  logic       mem_ready = 1'b0;
  logic       stall = 1'b0;
  logic [3:0] intr_req = '0;
  logic       intr_en = 1'b0;

  logic       pc_en, pc_load, fetch_req, instr_done;
  logic [1:0] pc_src, byte_idx;
  logic [2:0] addr_src;
  logic [3:0] intr_ack;

  int vectors = 0;
  int miscompares = 0;

  // {pc_en, pc_load, pc_src, addr_src, fetch_req, byte_idx, instr_done, intr_ack}
  typedef logic [14:0] ovec_t;

  typedef struct packed {
    logic       rst;
    logic [1:0] len;
    logic       mr;
    logic       st;
    logic [3:0] irq;
    logic       ien;
    logic [3:0] op;
    logic [1:0] b;
    logic [3:0] fl;
  } stim_t;

  stim_t sb_stim[$];
  ovec_t sb_exp[$];
  ovec_t w_out;

  always #5 clk = ~clk;

  pc_fetch_seq #(.MAX_BYTES(3), .NUM_VEC(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .brx         (brx),
    .flags       (flags),
    .instr_bytes (instr_bytes),
    .mem_ready   (mem_ready),
    .stall       (stall),
    .intr_req    (intr_req),
    .intr_en     (intr_en),
    .pc_en       (pc_en),
    .pc_load     (pc_load),
    .pc_src      (pc_src),
    .addr_src    (addr_src),
    .fetch_req   (fetch_req),
    .byte_idx    (byte_idx),
    .instr_done  (instr_done),
    .intr_ack    (intr_ack)
  );

  assign w_out = {pc_en, pc_load, pc_src, addr_src, fetch_req, byte_idx, instr_done, intr_ack};

  function automatic ovec_t mk(input logic en, input logic ld, input logic [1:0] src,
                               input logic [2:0] as, input logic fr, input logic [1:0] bi,
                               input logic dn, input logic [3:0] ack);
    return {en, ld, src, as, fr, bi, dn, ack};
  endfunction

  function automatic ovec_t o_reset();  return mk(1, 1, 2'b01, 3'd1, 0, 2'd0, 0, 4'b0); endfunction
  function automatic ovec_t o_fhold();  return mk(0, 0, 2'b00, 3'd0, 1, 2'd0, 0, 4'b0); endfunction
  function automatic ovec_t o_finc();   return mk(1, 0, 2'b00, 3'd0, 1, 2'd0, 0, 4'b0); endfunction
  function automatic ovec_t o_fx(input logic en, input logic [1:0] idx);
    return mk(en, 0, 2'b00, 3'd0, 1, idx, 0, 4'b0);
  endfunction
  function automatic ovec_t o_done();   return mk(0, 0, 2'b00, 3'd0, 0, 2'd0, 1, 4'b0); endfunction
  function automatic ovec_t o_load(input logic [1:0] src, input logic [2:0] as, input logic [3:0] ack);
    return mk(1, 1, src, as, 0, 2'd0, 1, ack);
  endfunction

  function automatic stim_t sv(input logic rst, input logic [1:0] len, input logic mr, input logic st,
                               input logic [3:0] irq, input logic ien, input logic [3:0] op,
                               input logic [1:0] b, input logic [3:0] fl);
    return '{rst: rst, len: len, mr: mr, st: st, irq: irq, ien: ien, op: op, b: b, fl: fl};
  endfunction

  task automatic push(input stim_t s, input ovec_t e);
    sb_stim.push_back(s);
    sb_exp.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    @(posedge clk);
    #1;
    reset = s.rst; instr_bytes = s.len; mem_ready = s.mr; stall = s.st;
    intr_req = s.irq; intr_en = s.ien; opcode = s.op; brx = s.b; flags = s.fl;
    @(negedge clk);
  endtask

  task automatic test_reset();
    ovec_t exp;
    int n = 0;
    push(sv(1, 1, 1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_reset());
    push(sv(1, 1, 1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_reset());
    push(sv(0, 1, 1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_reset());
    push(sv(0, 1, 1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_fhold());
    push(sv(0, 1, 1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_done());
    push(sv(0, 1, 1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_finc());
    push(sv(0, 1, 1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_done());
    while (sb_stim.size() > 0) begin
      apply(sb_stim.pop_front());
      exp = sb_exp.pop_front();
      vectors++;
      if (w_out !== exp) begin
        miscompares++;
        $display("FAIL reset_seq step %0d: got %b required %b", n, w_out, exp);
      end
      n++;
    end
  endtask

  task automatic test_multibyte();
    ovec_t exp;
    int n = 0;
    push(sv(0, 3, 1, 1, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_fhold());
    push(sv(0, 3, 1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_finc());
    push(sv(0, 3, 0, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_fx(0, 2'd1));
    push(sv(0, 3, 0, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_fx(0, 2'd1));
    push(sv(0, 3, 1, 1, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_fx(0, 2'd1));
    push(sv(0, 3, 1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_fx(1, 2'd1));
    push(sv(0, 3, 1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_fx(1, 2'd2));
    push(sv(0, 3, 1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_done());
    push(sv(0, 2, 1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_finc());
    push(sv(0, 2, 1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_fx(1, 2'd1));
    push(sv(0, 2, 1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_done());
    while (sb_stim.size() > 0) begin
      apply(sb_stim.pop_front());
      exp = sb_exp.pop_front();
      vectors++;
      if (w_out !== exp) begin
        miscompares++;
        $display("FAIL multibyte step %0d: got %b required %b", n, w_out, exp);
      end
      n++;
    end
  endtask

  task automatic test_intr();
    ovec_t exp;
    int n = 0;
    push(sv(0, 1, 1, 0, 4'b0110, 1, 4'd0, 2'd0, 4'h0), o_finc());
    push(sv(0, 1, 1, 0, 4'b0000, 1, 4'd0, 2'd0, 4'h0), o_load(2'b01, 3'd3, 4'b0010));
    push(sv(0, 1, 1, 0, 4'b0000, 1, 4'd0, 2'd0, 4'h0), o_fhold());
    push(sv(0, 1, 1, 0, 4'b0000, 1, 4'd0, 2'd0, 4'h0), o_load(2'b01, 3'd4, 4'b0100));
    push(sv(0, 1, 1, 0, 4'b0000, 1, 4'd0, 2'd0, 4'h0), o_fhold());
    push(sv(0, 1, 1, 0, 4'b0000, 1, 4'd0, 2'd0, 4'h0), o_done());
    // request re-raised in the same cycle it is acknowledged
    push(sv(0, 1, 1, 0, 4'b0001, 1, 4'd0, 2'd0, 4'h0), o_finc());
    push(sv(0, 1, 1, 0, 4'b0001, 1, 4'd0, 2'd0, 4'h0), o_load(2'b01, 3'd2, 4'b0001));
    push(sv(0, 1, 1, 0, 4'b0000, 1, 4'd0, 2'd0, 4'h0), o_fhold());
    push(sv(0, 1, 1, 0, 4'b0000, 1, 4'd0, 2'd0, 4'h0), o_load(2'b01, 3'd2, 4'b0001));
    push(sv(0, 1, 1, 0, 4'b0000, 1, 4'd0, 2'd0, 4'h0), o_fhold());
    push(sv(0, 1, 1, 0, 4'b0000, 1, 4'd0, 2'd0, 4'h0), o_done());
    while (sb_stim.size() > 0) begin
      apply(sb_stim.pop_front());
      exp = sb_exp.pop_front();
      vectors++;
      if (w_out !== exp) begin
        miscompares++;
        $display("FAIL intr step %0d: got %b required %b", n, w_out, exp);
      end
      n++;
    end
  endtask

  task automatic test_branch();
    ovec_t exp;
    int n = 0;
    push(sv(0, 1, 1, 0, 4'b0001, 0, 4'd0,  2'd0, 4'h0),    o_finc());
    push(sv(0, 1, 1, 0, 4'b0000, 0, 4'd9,  2'd2, 4'b0100), o_load(2'b00, 3'd0, 4'b0));
    push(sv(0, 1, 1, 0, 4'b0000, 1, 4'd0,  2'd0, 4'h0),    o_fhold());
    push(sv(0, 1, 1, 0, 4'b0000, 1, 4'd9,  2'd2, 4'b0100), o_load(2'b01, 3'd2, 4'b0001));
    push(sv(0, 1, 1, 0, 4'b0000, 0, 4'd0,  2'd0, 4'h0),    o_fhold());
    push(sv(0, 1, 1, 0, 4'b0000, 1, 4'd9,  2'd2, 4'b1011), o_done());
    push(sv(0, 1, 1, 0, 4'b0000, 0, 4'd0,  2'd0, 4'h0),    o_finc());
    push(sv(0, 1, 1, 0, 4'b0000, 0, 4'd10, 2'd0, 4'b1110), o_load(2'b00, 3'd0, 4'b0));
    push(sv(0, 1, 1, 0, 4'b0000, 0, 4'd0,  2'd0, 4'h0),    o_fhold());
    push(sv(0, 1, 1, 0, 4'b0000, 0, 4'd10, 2'd0, 4'b0001), o_done());
    push(sv(0, 1, 1, 0, 4'b0000, 0, 4'd0,  2'd0, 4'h0),    o_finc());
    push(sv(0, 1, 1, 0, 4'b0000, 0, 4'd11, 2'd1, 4'h0),    o_load(2'b10, 3'd0, 4'b0));
    push(sv(0, 1, 1, 0, 4'b0000, 0, 4'd0,  2'd0, 4'h0),    o_fhold());
    push(sv(0, 1, 1, 0, 4'b0000, 0, 4'd11, 2'd3, 4'h0),    o_load(2'b11, 3'd0, 4'b0));
    push(sv(0, 1, 1, 0, 4'b0000, 0, 4'd0,  2'd0, 4'h0),    o_fhold());
    push(sv(0, 1, 0, 1, 4'b0000, 0, 4'd0,  2'd0, 4'h0),    o_done());
    while (sb_stim.size() > 0) begin
      apply(sb_stim.pop_front());
      exp = sb_exp.pop_front();
      vectors++;
      if (w_out !== exp) begin
        miscompares++;
        $display("FAIL branch step %0d: got %b required %b", n, w_out, exp);
      end
      n++;
    end
  endtask

  task automatic test_clamp();
    ovec_t exp;
    int n = 0;
    push(sv(0, 2'd0,   1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_finc());
    push(sv(0, 2'd0,   1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_done());
    push(sv(0, 2'(7),  1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_finc());
    push(sv(0, 2'(7),  1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_fx(1, 2'd1));
    push(sv(0, 2'(7),  1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_fx(1, 2'd2));
    push(sv(0, 2'(7),  1, 0, 4'h0, 0, 4'd0, 2'd0, 4'h0), o_done());
    while (sb_stim.size() > 0) begin
      apply(sb_stim.pop_front());
      exp = sb_exp.pop_front();
      vectors++;
      if (w_out !== exp) begin
        miscompares++;
        $display("FAIL clamp step %0d: got %b required %b", n, w_out, exp);
      end
      n++;
    end
  endtask

  task automatic test_reset_midfetch();
    ovec_t exp;
    int n = 0;
    push(sv(0, 3, 1, 0, 4'b0001, 0, 4'd0, 2'd0, 4'h0), o_finc());
    push(sv(1, 3, 0, 0, 4'b0000, 1, 4'd0, 2'd0, 4'h0), o_fx(0, 2'd1));
    push(sv(0, 1, 1, 0, 4'b0000, 1, 4'd0, 2'd0, 4'h0), o_reset());
    push(sv(0, 1, 1, 0, 4'b0000, 1, 4'd0, 2'd0, 4'h0), o_fhold());
    push(sv(0, 1, 1, 0, 4'b0000, 1, 4'd0, 2'd0, 4'h0), o_done());
    while (sb_stim.size() > 0) begin
      apply(sb_stim.pop_front());
      exp = sb_exp.pop_front();
      vectors++;
      if (w_out !== exp) begin
        miscompares++;
        $display("FAIL reset_midfetch step %0d: got %b required %b", n, w_out, exp);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_multibyte();
    test_intr();
    test_branch();
    test_clamp();
    test_reset_midfetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
